param_stack: RTL and testbench

Parameter (data) stack for the Forth core. Holds the second-on-stack element (NOS) in a register and spills deeper elements into a small register-file array. Sits directly upstream of the TOS datapath: drives pstack_top to the ALU/adder argument path and to the memory write-data path, and captures the outgoing TOS on push. The decoder issues push/pop per instruction; wait_state freezes the stack in lock-step with the TOS register.

---
 rtl/param_stack.sv | 135 +++++++++++++
 tb/tb_param_stack.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// rtl/param_stack.sv - Forth parameter stack: NOS register plus ring-buffer spill array
//
// Optional feature macro: PSTACK_PICK_EN (adds pick_idx / pick_data read port)
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   wait_state  in   stall; push/pop ignored while high (err_clr still honoured)
//   push        in   push push_data (NOS spills into the array)
//   pop         in   pop (NOS reloads from the array); push+pop = replace NOS
//   push_data   in   [width]   value pushed, normally the current TOS
//   err_clr     in   synchronous clear of the sticky overflow/underflow flags
//   pick_idx    in   [PTR_W+1] (PSTACK_PICK_EN) element index, 0 = NOS
//   pick_data   out  [width]   (PSTACK_PICK_EN) element at pick_idx, 0 if beyond depth
//   pstack_top  out  [width]   current NOS, registered
//   depth       out  [PTR_W+1] number of valid elements, 0..DEPTH+1
//   empty       out  depth == 0
//   full        out  depth == DEPTH+1
//   overflow    out  sticky: push while full
//   underflow   out  sticky: pop while empty

module param_stack #(
  parameter int width = 16,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wait_state,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] push_data,
  input  logic             err_clr,
`ifdef PSTACK_PICK_EN
  input  logic [PTR_W:0]   pick_idx,
  output logic [width-1:0] pick_data,
`endif
  output logic [width-1:0] pstack_top,
  output logic [PTR_W:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH = 2 ** PTR_W;
  localparam logic [PTR_W:0] CAP   = (PTR_W + 1)'(DEPTH + 1);

  logic [width-1:0] r_arr [DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [PTR_W:0]   r_depth;
  logic [width-1:0] r_top;
  logic             r_ovf;
  logic             r_unf;

  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_repl;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W-1:0] w_sp_dec;
  logic [PTR_W-1:0] w_sp_inc;

  assign w_do_push = ~wait_state &  push & ~pop;
  assign w_do_pop  = ~wait_state & ~push &  pop;
  assign w_do_repl = ~wait_state &  push &  pop;
  assign w_full    = (r_depth == CAP);
  assign w_empty   = (r_depth == '0);
  assign w_sp_dec  = r_sp - PTR_W'(1);
  assign w_sp_inc  = r_sp + PTR_W'(1);

  // Spill array is never reset; the outgoing NOS is written even when the
  // stack is empty or full (full push overwrites the oldest entry by wrap).
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      r_arr[r_sp] <= r_top;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_depth <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_top <= push_data;
        r_sp  <= w_sp_inc;
        if (!w_full) begin
          r_depth <= r_depth + 1'b1;
        end
      end else if (w_do_pop) begin
        if (w_empty) begin
          r_top <= '0;
        end else begin
          // At depth 1 this reloads a stale array entry; depth marks it invalid.
          r_top   <= r_arr[w_sp_dec];
          r_sp    <= w_sp_dec;
          r_depth <= r_depth - 1'b1;
        end
      end else if (w_do_repl) begin
        r_top <= push_data;
      end

      // A new error in the same cycle as err_clr wins.
      r_ovf <= (r_ovf & ~err_clr) | (w_do_push & w_full);
      r_unf <= (r_unf & ~err_clr) | (w_do_pop & w_empty);
    end
  end

`ifdef PSTACK_PICK_EN
  logic [PTR_W-1:0] w_pick_addr;
  assign w_pick_addr = r_sp - pick_idx[PTR_W-1:0];

  always_comb begin
    pick_data = '0;
    if (pick_idx < r_depth) begin
      if (pick_idx == '0) begin
        pick_data = r_top;
      end else begin
        pick_data = r_arr[w_pick_addr];
      end
    end
  end
`endif

  assign pstack_top = r_top;
  assign depth      = r_depth;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - self-checking bench for param_stack (PTR_W=2, capacity 5)

module tb_param_stack;

  localparam int W   = 16;
  localparam int PW  = 2;
  localparam int CAP = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wait_state;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_data;
  logic          err_clr;
  logic [W-1:0]  pstack_top;
  logic [PW:0]   depth;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
`ifdef PSTACK_PICK_EN
  logic [PW:0]   pick_idx;
  logic [W-1:0]  pick_data;
`endif

  param_stack #(.width(W), .PTR_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wait_state (wait_state),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .err_clr    (err_clr),
`ifdef PSTACK_PICK_EN
    .pick_idx   (pick_idx),
    .pick_data  (pick_data),
`endif
    .pstack_top (pstack_top),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         wt;
    logic         ps;
    logic         pp;
    logic         clr;
    logic [W-1:0] d;
    logic [W-1:0] et;
    int           ed;
    logic         eo;
    logic         eu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wt, input logic ps, input logic pp, input logic clr,
                     input logic [W-1:0] d, input logic [W-1:0] et, input int ed,
                     input logic eo, input logic eu);
    vec_t v;
    v.wt = wt; v.ps = ps; v.pp = pp; v.clr = clr; v.d = d;
    v.et = et; v.ed = ed; v.eo = eo; v.eu = eu;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_state(input int idx, input int ed, input logic eo, input logic eu);
    chk("depth", idx, 32'(depth), 32'(ed));
    chk("empty", idx, 32'(empty), 32'(ed == 0));
    chk("full", idx, 32'(full), 32'(ed == CAP));
    chk("overflow", idx, 32'(overflow), 32'(eo));
    chk("underflow", idx, 32'(underflow), 32'(eu));
  endtask

  task automatic step(input logic wt, input logic ps, input logic pp, input logic clr,
                      input logic [W-1:0] d);
    wait_state = wt; push = ps; pop = pp; err_clr = clr; push_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wait_state = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Reference model: logical stack as a queue (back = NOS), bounded to CAP.
  logic [W-1:0] q[$];
  logic [W-1:0] m_top;
  bit           m_top_known;
  bit           m_ovf;
  bit           m_unf;

  initial begin
    reset = 1'b1;
    idle_inputs();
`ifdef PSTACK_PICK_EN
    pick_idx = '0;
`endif
    #12;
    chk("reset_top", -1, 32'(pstack_top), 32'h0);
    chk_state(-1, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-cycle while a push is held and underflow is set.
    step(0, 1, 0, 0, 16'h0099);
    chk("ar_top0", -2, 32'(pstack_top), 32'h0099);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    chk("ar_unf", -2, 32'(underflow), 32'h1);
    @(negedge clk);
    push = 1'b1; push_data = 16'h4444;
    #2 reset = 1'b1;
    #1;
    chk("ar_top", -2, 32'(pstack_top), 32'h0);
    chk_state(-2, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_hold_top", -3, 32'(pstack_top), 32'h0);
    chk("ar_hold_depth", -3, 32'(depth), 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;

    // Table: basic LIFO, wrap/overflow, underflow, err_clr, replace, stall.
    add(0,1,0,0,16'h0011,16'h0011,1,0,0);
    add(0,1,0,0,16'h0022,16'h0022,2,0,0);
    add(0,1,0,0,16'h0033,16'h0033,3,0,0);
    add(0,0,1,0,16'h0000,16'h0022,2,0,0);
    add(0,0,1,0,16'h0000,16'h0011,1,0,0);
    add(0,0,1,0,16'h0000,16'h0000,0,0,0);
    add(0,1,0,0,16'h0001,16'h0001,1,0,0);
    add(0,1,0,0,16'h0002,16'h0002,2,0,0);
    add(0,1,0,0,16'h0003,16'h0003,3,0,0);
    add(0,1,0,0,16'h0004,16'h0004,4,0,0);
    add(0,1,0,0,16'h0005,16'h0005,5,0,0);
    add(0,1,0,0,16'h0006,16'h0006,5,1,0);
    add(0,0,1,0,16'h0000,16'h0005,4,1,0);
    add(0,0,1,0,16'h0000,16'h0004,3,1,0);
    add(0,0,1,0,16'h0000,16'h0003,2,1,0);
    add(0,0,1,0,16'h0000,16'h0002,1,1,0);
    add(0,0,1,0,16'h0000,16'h0005,0,1,0);
    add(0,0,0,1,16'h0000,16'h0005,0,0,0);
    add(0,0,1,0,16'h0000,16'h0000,0,0,1);
    add(0,0,0,0,16'h0000,16'h0000,0,0,1);
    add(0,0,0,1,16'h0000,16'h0000,0,0,0);
    add(0,0,1,1,16'h0000,16'h0000,0,0,1);
    add(0,0,0,1,16'h0000,16'h0000,0,0,0);
    add(0,1,1,0,16'h0077,16'h0077,0,0,0);
    add(0,1,0,0,16'hAAAA,16'hAAAA,1,0,0);
    add(0,1,0,0,16'hBEEF,16'hBEEF,2,0,0);
    add(0,1,1,0,16'h1234,16'h1234,2,0,0);
    add(0,0,1,0,16'h0000,16'hAAAA,1,0,0);
    add(1,1,0,0,16'h5555,16'hAAAA,1,0,0);
    add(1,1,0,0,16'h5555,16'hAAAA,1,0,0);
    add(1,1,0,0,16'h5555,16'hAAAA,1,0,0);
    add(0,1,0,0,16'h5555,16'h5555,2,0,0);
    add(1,0,1,1,16'h0000,16'h5555,2,0,0);
    add(0,0,1,0,16'h0000,16'hAAAA,1,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].wt, tbl[i].ps, tbl[i].pp, tbl[i].clr, tbl[i].d);
      chk("top", i, 32'(pstack_top), 32'(tbl[i].et));
      chk_state(i, tbl[i].ed, tbl[i].eo, tbl[i].eu);
    end
    idle_inputs();

    // err_clr during a stall still clears a sticky flag.
    do_reset();
    step(0, 0, 1, 0, 16'h0);
    step(1, 0, 1, 1, 16'h0);
    chk("stall_clr_unf", 100, 32'(underflow), 32'h0);
    step(1, 0, 1, 0, 16'h0);
    chk("stall_no_unf", 101, 32'(underflow), 32'h0);

`ifdef PSTACK_PICK_EN
    do_reset();
    step(0, 1, 0, 0, 16'h000A);
    step(0, 1, 0, 0, 16'h000B);
    step(0, 1, 0, 0, 16'h000C);
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] pexp [5];
      pexp = '{16'h000C, 16'h000B, 16'h000A, 16'h0000, 16'h0000};
      pick_idx = (PW + 1)'(k);
      #1;
      chk("pick", 200 + k, 32'(pick_data), 32'(pexp[k]));
    end
`endif

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    m_top = '0; m_top_known = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic wt, ps, pp, clr;
      logic [W-1:0] d;
      wt  = ($urandom_range(0, 4) == 0);
      ps  = 1'($urandom_range(0, 1));
      pp  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 9) == 0);
      d   = W'($urandom);
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (!wt) begin
        if (ps && !pp) begin
          if (q.size() == CAP) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
          end
          q.push_back(d);
          m_top = d; m_top_known = 1'b1;
        end else if (!ps && pp) begin
          if (q.size() == 0) begin
            m_unf = 1'b1;
            m_top = '0; m_top_known = 1'b1;
          end else begin
            void'(q.pop_back());
            if (q.size() > 0) begin
              m_top = q[$]; m_top_known = 1'b1;
            end else begin
              m_top_known = 1'b0;
            end
          end
        end else if (ps && pp) begin
          if (q.size() > 0) q[$] = d;
          m_top = d; m_top_known = 1'b1;
        end
      end
      step(wt, ps, pp, clr, d);
      if (m_top_known) chk("rnd_top", 1000 + n, 32'(pstack_top), 32'(m_top));
      chk_state(1000 + n, q.size(), m_ovf, m_unf);
`ifdef PSTACK_PICK_EN
      begin
        int pi;
        logic [W-1:0] pe;
        pi = $urandom_range(0, CAP);
        pe = (pi < q.size()) ? q[q.size() - 1 - pi] : '0;
        pick_idx = (PW + 1)'(pi);
        #1;
        chk("rnd_pick", 1000 + n, 32'(pick_data), 32'(pe));
      end
`endif
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
